short_stack_unit: RTL

- Per-ray short-stack and restart-state store for kd-tree traversal.
- Consumes the push/pop/update_restnode/update_maxscene requests produced by the traversal unit.
- A pop resolves to a node fetch sent to the traversal arbiter (tarb), or to a scene-miss report to the shader.
- Holds the restart node and the scene t_max limit per ray, which gives kd-restart fallback when the short stack underflows.

---
 rtl/short_stack_unit_pkg.sv | 53 +++++
 rtl/short_stack_unit_ss_ram.sv | 31 +++
 rtl/short_stack_unit.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/short_stack_unit_pkg.sv
// Shared types and constants for the per-ray short-stack unit.
// Request/response layouts match the traversal unit and traversal arbiter.
package short_stack_unit_pkg;

    localparam int unsigned NUM_RAYS    = 256;
    localparam int unsigned RAYID_W     = $clog2(NUM_RAYS);
    localparam int unsigned STACK_DEPTH = 4;
    localparam int unsigned PTR_W       = 2;
    localparam int unsigned NUM_W       = 3;
    localparam int unsigned NODE_W      = 32;

    typedef logic [RAYID_W-1:0] rayID_t;
    typedef logic [NODE_W-1:0]  nodeID_t;
    typedef logic [31:0]        float_t;

    localparam nodeID_t ROOT_ID = '0;

    typedef struct packed {
        rayID_t           rayID;
        logic [PTR_W-1:0] ss_wptr;
        logic [NUM_W-1:0] ss_num;
    } ray_info_t;

    typedef struct packed {
        ray_info_t ray_info;
        logic      push_req;
        nodeID_t   push_node_ID;
        logic      update_restnode_req;
        nodeID_t   rest_node_ID;
        float_t    t_max;
        logic      pop_req;
        logic      update_maxscene_req;
    } trav_to_ss_t;

    typedef struct packed {
        ray_info_t ray_info;
        nodeID_t   nodeID;
        logic      restnode_search;
        float_t    t_max;
        float_t    t_min;
    } tarb_t;

    typedef struct packed {
        nodeID_t nodeID;
        float_t  t_max;
    } stack_entry_t;

    // Non-negative IEEE floats order the same as their unsigned bit patterns.
    function automatic logic float_lt(input float_t a, input float_t b);
        return a < b;
    endfunction

endpackage

// File: rtl/short_stack_unit_ss_ram.sv
// 1-read/1-write synchronous RAM with a registered, enable-gated read port.
// The read register holds its value while re_i is low.
module ss_ram #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 256,
    localparam int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/short_stack_unit.sv
// Per-ray short stack plus restart node / scene t_max store for kd-tree traversal.
// Two stages: S0 accepts and reads the RAMs, S1 resolves, writes and loads the outputs.
module short_stack_unit
    import short_stack_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ray_init_valid,
    input  rayID_t      ray_init_rayID,
    input  float_t      ray_init_t_max,
    input  logic        trav_to_ss_valid,
    input  trav_to_ss_t trav_to_ss_data,
    output logic        trav_to_ss_stall,
    output logic        ss_to_tarb_valid,
    output tarb_t       ss_to_tarb_data,
    input  logic        ss_to_tarb_stall,
    output logic        ss_to_shader_valid,
    output rayID_t      ss_to_shader_data,
    input  logic        ss_to_shader_stall
);

    logic         accept;
    logic         s1_valid_q, s1_valid_d;
    trav_to_ss_t  s1_req_q, s1_req_d;
    logic         tarb_valid_q, tarb_valid_d;
    tarb_t        tarb_data_q, tarb_data_d;
    logic         shd_valid_q, shd_valid_d;
    rayID_t       shd_data_q, shd_data_d;

    stack_entry_t stack_rd;
    nodeID_t      rest_rd;
    float_t       max_rd;

    logic         pop_hit, to_tarb, to_shader, init_conflict, s1_fire;
    tarb_t        tarb_new;

    logic [RAYID_W+PTR_W-1:0] stack_raddr, stack_waddr;
    logic                     rest_we, max_we;
    rayID_t                   rest_waddr, max_waddr;
    nodeID_t                  rest_wdata;
    float_t                   max_wdata;

    assign accept      = trav_to_ss_valid & ~trav_to_ss_stall;
    assign stack_raddr = {trav_to_ss_data.ray_info.rayID, trav_to_ss_data.ray_info.ss_wptr - 2'd1};
    assign stack_waddr = {s1_req_q.ray_info.rayID, s1_req_q.ray_info.ss_wptr};

    always_comb begin
        pop_hit   = s1_req_q.ray_info.ss_num != '0;
        to_tarb   = s1_valid_q & s1_req_q.pop_req & (pop_hit | float_lt(s1_req_q.t_max, max_rd));
        to_shader = s1_valid_q & s1_req_q.pop_req & ~to_tarb;
        // ray_init owns the restnode/maxscene write ports for its cycle
        init_conflict = ray_init_valid &
                        (s1_req_q.update_restnode_req | s1_req_q.update_maxscene_req);
        if (to_tarb) begin
            s1_fire = ~tarb_valid_q | ~ss_to_tarb_stall;
        end else if (to_shader) begin
            s1_fire = ~shd_valid_q | ~ss_to_shader_stall;
        end else begin
            s1_fire = s1_valid_q & ~init_conflict;
        end
        trav_to_ss_stall = s1_valid_q & ~s1_fire;

        tarb_new          = '0;
        tarb_new.ray_info = s1_req_q.ray_info;
        tarb_new.t_min    = s1_req_q.t_max;
        if (pop_hit) begin
            tarb_new.ray_info.ss_wptr = s1_req_q.ray_info.ss_wptr - 2'd1;
            tarb_new.ray_info.ss_num  = s1_req_q.ray_info.ss_num - 3'd1;
            tarb_new.nodeID           = stack_rd.nodeID;
            tarb_new.t_max            = stack_rd.t_max;
        end else begin
            tarb_new.nodeID          = rest_rd;
            tarb_new.t_max           = max_rd;
            tarb_new.restnode_search = 1'b1;
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q & ~s1_fire;
        s1_req_d   = s1_req_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_req_d   = trav_to_ss_data;
        end

        tarb_valid_d = tarb_valid_q & ss_to_tarb_stall;
        tarb_data_d  = tarb_data_q;
        if (s1_fire && to_tarb) begin
            tarb_valid_d = 1'b1;
            tarb_data_d  = tarb_new;
        end

        shd_valid_d = shd_valid_q & ss_to_shader_stall;
        shd_data_d  = shd_data_q;
        if (s1_fire && to_shader) begin
            shd_valid_d = 1'b1;
            shd_data_d  = s1_req_q.ray_info.rayID;
        end

        rest_we    = ray_init_valid | (s1_fire & s1_req_q.update_restnode_req);
        rest_waddr = ray_init_valid ? ray_init_rayID : s1_req_q.ray_info.rayID;
        rest_wdata = ray_init_valid ? ROOT_ID : s1_req_q.rest_node_ID;
        max_we     = ray_init_valid | (s1_fire & s1_req_q.update_maxscene_req);
        max_waddr  = ray_init_valid ? ray_init_rayID : s1_req_q.ray_info.rayID;
        max_wdata  = ray_init_valid ? ray_init_t_max : s1_req_q.t_max;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q   <= 1'b0;
            s1_req_q     <= '0;
            tarb_valid_q <= 1'b0;
            tarb_data_q  <= '0;
            shd_valid_q  <= 1'b0;
            shd_data_q   <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_req_q     <= s1_req_d;
            tarb_valid_q <= tarb_valid_d;
            tarb_data_q  <= tarb_data_d;
            shd_valid_q  <= shd_valid_d;
            shd_data_q   <= shd_data_d;
        end
    end

    assign ss_to_tarb_valid   = tarb_valid_q;
    assign ss_to_tarb_data    = tarb_data_q;
    assign ss_to_shader_valid = shd_valid_q;
    assign ss_to_shader_data  = shd_data_q;

    ss_ram #(.Width($bits(stack_entry_t)), .Depth(NUM_RAYS * STACK_DEPTH)) u_stack_ram (
        .clk_i   (clk),
        .we_i    (s1_fire & s1_req_q.push_req),
        .waddr_i (stack_waddr),
        .wdata_i ({s1_req_q.push_node_ID, s1_req_q.t_max}),
        .re_i    (accept),
        .raddr_i (stack_raddr),
        .rdata_o (stack_rd)
    );

    ss_ram #(.Width($bits(nodeID_t)), .Depth(NUM_RAYS)) u_restnode_ram (
        .clk_i   (clk),
        .we_i    (rest_we),
        .waddr_i (rest_waddr),
        .wdata_i (rest_wdata),
        .re_i    (accept),
        .raddr_i (trav_to_ss_data.ray_info.rayID),
        .rdata_o (rest_rd)
    );

    ss_ram #(.Width($bits(float_t)), .Depth(NUM_RAYS)) u_maxscene_ram (
        .clk_i   (clk),
        .we_i    (max_we),
        .waddr_i (max_waddr),
        .wdata_i (max_wdata),
        .re_i    (accept),
        .raddr_i (trav_to_ss_data.ray_info.rayID),
        .rdata_o (max_rd)
    );

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst && accept) begin
            assert (!(trav_to_ss_data.pop_req && (trav_to_ss_data.push_req ||
                    trav_to_ss_data.update_restnode_req || trav_to_ss_data.update_maxscene_req)))
            else $error("pop combined with another request type");
            assert (trav_to_ss_data.pop_req || trav_to_ss_data.push_req ||
                    trav_to_ss_data.update_restnode_req || trav_to_ss_data.update_maxscene_req)
            else $warning("request with no type bit set dropped");
            assert (!(s1_valid_q && s1_req_q.ray_info.rayID == trav_to_ss_data.ray_info.rayID))
            else $error("second request for a ray already in flight");
        end
    end
`endif

endmodule
